// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Default cycle counts assume a 50 MHz system clock.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    REPEAT,
    DEB_RELEASE
  } btn_state_t;

  // 20 ms debounce, 500 ms before auto-repeat, then 10 steps per second
  localparam int DEFAULT_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5_000_000;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input.
// Reset loads a chosen idle level so no false edge appears after reset.
module sync_2ff #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_step_conditioner.sv
// Turns a raw push-button into debounced single-cycle step strobes with optional
// hold-to-repeat, plus a debounced level and a release strobe. All outputs registered.
module button_step_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN           = 1'b1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
  parameter bit ACTIVE_LOW          = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic step_pulse,
  output logic release_pulse
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(max_cycles(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);

  localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_delay
    $error("REPEAT_DELAY_CYCLES must be >= 1");
  end
  if (REPEAT_RATE_CYCLES < 1) begin : g_bad_rate
    $error("REPEAT_RATE_CYCLES must be >= 1");
  end

  logic synced;
  logic p;

  sync_2ff #(
    .RESET_VALUE(ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw),
    .q    (synced)
  );

  // p is the synchronized sample in pressed-is-1 form regardless of board polarity
  always_comb p = synced ^ ACTIVE_LOW;

  btn_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic              step_next, release_next, level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      btn_level     <= 1'b0;
      step_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      hold          <= hold_next;
      btn_level     <= level_next;
      step_pulse    <= step_next;
      release_pulse <= release_next;
    end
  end

  // A release that bounces back lands in PRESSED with a fresh hold timer,
  // so the repeat delay restarts rather than firing early.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hold_next  = hold;
    case (state)
      IDLE: begin
        if (p) begin
          state_next = DEB_PRESS;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      DEB_PRESS: begin
        if (!p) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_DONE) begin
          state_next = PRESSED;
          cnt_next   = '0;
          hold_next  = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_next = DEB_RELEASE;
          cnt_next   = CNT_W'(1);
        end else if (hold == DELAY_LAST) begin
          // with repeat disabled the timer parks here instead of wrapping
          if (REPEAT_EN) begin
            state_next = REPEAT;
            hold_next  = '0;
          end
        end else begin
          hold_next = hold + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (!p) begin
          state_next = DEB_RELEASE;
          cnt_next   = CNT_W'(1);
        end else if (hold == RATE_LAST) begin
          hold_next = '0;
        end else begin
          hold_next = hold + HOLD_W'(1);
        end
      end
      DEB_RELEASE: begin
        if (p) begin
          state_next = PRESSED;
          cnt_next   = '0;
          hold_next  = '0;
        end else if (cnt == CNT_DONE) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        hold_next  = '0;
      end
    endcase
  end

  always_comb begin
    step_next    = 1'b0;
    release_next = 1'b0;
    level_next   = (state_next == PRESSED) || (state_next == REPEAT) ||
                   (state_next == DEB_RELEASE);
    case (state)
      DEB_PRESS:   step_next    = p && (cnt == CNT_DONE);
      PRESSED:     step_next    = p && REPEAT_EN && (hold == DELAY_LAST);
      REPEAT:      step_next    = p && (hold == RATE_LAST);
      DEB_RELEASE: release_next = !p && (cnt == CNT_DONE);
      default: begin
        step_next    = 1'b0;
        release_next = 1'b0;
      end
    endcase
  end

endmodule
